// File: rtl/cordic_sequencer.sv
// cordic_sequencer: hardware sequencer for the iterative CORDIC core.
// Accepts one request over valid/ready, loads the core, steps it through
// p_NUM_ITER iterations while collecting overflow flags, then presents the
// final core state until the consumer accepts it.
//
// Optional build macro: CORDIC_SEQ_EARLY_STOP_EN
//   defined   - an overflow ends the iteration run early
//   undefined - every operation runs all p_NUM_ITER iterations
module cordic_sequencer #(
  parameter int unsigned p_WIDTH    = 32,
  parameter int unsigned p_NUM_ITER = 30,
  parameter int unsigned p_ITER_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  // request side
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_system,
  input  logic                in_mode,
  input  logic [p_WIDTH-1:0]  in_x,
  input  logic [p_WIDTH-1:0]  in_y,
  input  logic [p_WIDTH-1:0]  in_z,
  // result side
  output logic                out_valid,
  input  logic                out_ready,
  output logic [p_WIDTH-1:0]  out_x,
  output logic [p_WIDTH-1:0]  out_y,
  output logic [p_WIDTH-1:0]  out_z,
  output logic [2:0]          out_ov,
  output logic [p_ITER_W-1:0] out_ov_iter,
  // core control
  output logic                core_load,
  output logic                core_en,
  output logic [p_ITER_W-1:0] core_iter,
  output logic                core_system,
  output logic                core_mode,
  output logic [p_WIDTH-1:0]  core_x_in,
  output logic [p_WIDTH-1:0]  core_y_in,
  output logic [p_WIDTH-1:0]  core_z_in,
  // core state
  input  logic [p_WIDTH-1:0]  core_x,
  input  logic [p_WIDTH-1:0]  core_y,
  input  logic [p_WIDTH-1:0]  core_z,
  input  logic [2:0]          core_ov
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [p_ITER_W-1:0] LAST_ITER = p_ITER_W'(p_NUM_ITER - 1);

  state_t state;
  state_t state_nxt;

  logic accept;
  logic last_iter;
  logic ov_any;
  logic stop_now;
  logic stop_pending;

  assign accept    = (state == IDLE) && in_valid && in_ready;
  assign last_iter = (core_iter == LAST_ITER);
  assign ov_any    = |core_ov;

`ifdef CORDIC_SEQ_EARLY_STOP_EN
  // An overflowing iteration is the last one performed. One idle ITER cycle
  // (core_en low, core state frozen) follows before DONE, which keeps the
  // result latency at ov_iter+4 and the result equal to the post-overflow state.
  assign stop_now = core_en && ov_any && !last_iter;

  // Remember that the run was cut short so the next edge moves to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_pending <= 1'b0;
    end else begin
      stop_pending <= stop_now;
    end
  end
`else
  assign stop_now     = 1'b0;
  assign stop_pending = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid && in_ready)                 state_nxt = LOAD;
      LOAD:                                           state_nxt = ITER;
      ITER: if (stop_pending || (core_en && last_iter)) state_nxt = DONE;
      DONE: if (out_ready)                            state_nxt = IDLE;
      default:                                        state_nxt = IDLE;
    endcase
  end

  // State register and registered state-decoded strobes, so no handshake
  // input reaches a handshake output combinationally and all reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      core_load <= 1'b0;
      core_en   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      core_load <= (state_nxt == LOAD);
      core_en   <= (state_nxt == ITER) && !stop_now;
      out_valid <= (state_nxt == DONE);
    end
  end

  // Capture the request; held unchanged until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_system <= 1'b0;
      core_mode   <= 1'b0;
      core_x_in   <= '0;
      core_y_in   <= '0;
      core_z_in   <= '0;
    end else if (accept) begin
      core_system <= in_system;
      core_mode   <= in_mode;
      core_x_in   <= in_x;
      core_y_in   <= in_y;
      core_z_in   <= in_z;
    end
  end

  // Iteration index: zero through LOAD, advanced after each performed iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_iter <= '0;
    end else if (accept) begin
      core_iter <= '0;
    end else if (core_en && !last_iter) begin
      core_iter <= core_iter + 1'b1;
    end
  end

  // Sticky overflow flags and index of the first overflowing iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ov      <= '0;
      out_ov_iter <= '1;
    end else if (accept) begin
      out_ov      <= '0;
      out_ov_iter <= '1;
    end else if (core_en) begin
      out_ov <= out_ov | core_ov;
      if ((out_ov == 3'b000) && ov_any) begin
        out_ov_iter <= core_iter;
      end
    end
  end

  // The core holds its state while core_load and core_en are low, which is
  // the case for the whole DONE state, so its registers are the result
  // registers; gating with out_valid keeps partial values off the outputs.
  assign out_x = out_valid ? core_x : '0;
  assign out_y = out_valid ? core_y : '0;
  assign out_z = out_valid ? core_z : '0;

endmodule
